// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path: FSM state encoding,
// frame width and baud divisor calculation.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } uart_rx_state_t;

  // Clocks per bit cell minus one; clk_fre is in MHz, uart_rate in bit/s.
  function automatic int calc_rate_cnt(input int clk_fre, input int uart_rate);
    return (clk_fre * 1_000_000) / uart_rate - 1;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous serial input. Resets to the
// idle-high line level so a reset never looks like a start bit.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1, LSB first, mid-bit sampling from a clk-based baud counter.
// Optional macro UART_RX_FRAME_ERR_EN enables the frame_err pulse on a bad stop bit.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FRE   = 50,
  parameter int UART_RATE = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_pin,
  output logic       recv_valid,
  output logic [7:0] recv_data,
  output logic       recv_busy,
  output logic       frame_err
);

  localparam int          RATE_INT = calc_rate_cnt(CLK_FRE, UART_RATE);
  localparam logic [20:0] RATE_CNT = 21'(RATE_INT);
  localparam logic [20:0] HALF_CNT = 21'(RATE_INT / 2);

  // Output handshake: recv_valid is a one-cycle pulse with no back-pressure;
  // recv_data is valid in that cycle and holds until the next pulse.
  uart_rx_state_t         state;
  logic [20:0]            clk_cnt;
  logic [2:0]             bit_cnt;
  logic [DATA_BITS-1:0]   shift_r;
  logic                   rx_s;

  uart_rx_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx_pin),
    .q   (rx_s)
  );

  assign recv_busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      clk_cnt    <= '0;
      bit_cnt    <= '0;
      shift_r    <= '0;
      recv_data  <= '0;
      recv_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      recv_valid <= 1'b0;
      frame_err  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!rx_s) begin
            state   <= START;
            clk_cnt <= '0;
            bit_cnt <= '0;
          end
        end
        START: begin
          // A line that is high again at mid start bit was only a glitch.
          if (clk_cnt == HALF_CNT) begin
            clk_cnt <= '0;
            state   <= rx_s ? IDLE : DATA;
          end else begin
            clk_cnt <= clk_cnt + 21'd1;
          end
        end
        DATA: begin
          if (clk_cnt == RATE_CNT) begin
            clk_cnt          <= '0;
            shift_r[bit_cnt] <= rx_s;
            bit_cnt          <= bit_cnt + 3'd1;
            if (bit_cnt == 3'(DATA_BITS - 1)) state <= STOP;
          end else begin
            clk_cnt <= clk_cnt + 21'd1;
          end
        end
        STOP: begin
          // Leaving at mid stop bit leaves half a bit to catch the next start edge.
          if (clk_cnt == RATE_CNT) begin
            clk_cnt <= '0;
            if (rx_s) begin
              recv_data  <= shift_r;
              recv_valid <= 1'b1;
              state      <= IDLE;
            end else begin
`ifdef UART_RX_FRAME_ERR_EN
              frame_err <= 1'b1;
`endif
              state <= BREAK;
            end
          end else begin
            clk_cnt <= clk_cnt + 21'd1;
          end
        end
        BREAK: begin
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
